// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : GPR file with bypassed reads and a per-register pending-write
//            scoreboard that raises decode stalls on operand hazards.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int PEND_CNT_WIDTH  = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_act_write_res_to_reg,
    input  logic [IALU_WORD_WIDTH-1:0]    in_res,
    input  logic [REG_IDX_WIDTH-1:0]      in_res_reg_idx,
    input  logic                          in_cancel_valid,
    input  logic [REG_IDX_WIDTH-1:0]      in_cancel_reg_idx,
    input  logic [REG_IDX_WIDTH-1:0]      in_rd_idx_a,
    input  logic [REG_IDX_WIDTH-1:0]      in_rd_idx_b,
    input  logic                          in_rd_use_a,
    input  logic                          in_rd_use_b,
    input  logic                          in_issue_valid,
    input  logic [REG_IDX_WIDTH-1:0]      in_issue_reg_idx,
    output logic [IALU_WORD_WIDTH-1:0]    out_rd_data_a,
    output logic [IALU_WORD_WIDTH-1:0]    out_rd_data_b,
    output logic                          out_stall,
    output logic [(2**REG_IDX_WIDTH)-1:0] out_busy_mask,
    output logic                          out_underflow_err
);

    localparam int NREGS = 2**REG_IDX_WIDTH;
    // One extra bit holds the signed net result (-2 .. max) of a counter update.
    localparam int SW    = PEND_CNT_WIDTH + 1;
    localparam logic [PEND_CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [IALU_WORD_WIDTH-1:0] regs_q [NREGS];
    logic [PEND_CNT_WIDTH-1:0]  cnt_q  [NREGS];
    logic [PEND_CNT_WIDTH-1:0]  cnt_d  [NREGS];
    logic                       underflow_q;
    logic                       underflow_d;

    logic [NREGS-1:0] dec_wb;
    logic [NREGS-1:0] dec_cn;
    logic [NREGS-1:0] inc;
    logic             hazard_a;
    logic             hazard_b;
    logic             full_dest;
    logic             stall;

    always_comb begin
        dec_wb = '0;
        dec_cn = '0;
        for (int i = 0; i < NREGS; i++) begin
            dec_wb[i] = in_act_write_res_to_reg && (in_res_reg_idx == REG_IDX_WIDTH'(i));
            dec_cn[i] = in_cancel_valid && (in_cancel_reg_idx == REG_IDX_WIDTH'(i));
        end
    end

    // A source is ready once this cycle's retirements cover every pending writer.
    assign hazard_a = in_rd_use_a &&
        (SW'(cnt_q[in_rd_idx_a]) > (SW'(dec_wb[in_rd_idx_a]) + SW'(dec_cn[in_rd_idx_a])));
    assign hazard_b = in_rd_use_b &&
        (SW'(cnt_q[in_rd_idx_b]) > (SW'(dec_wb[in_rd_idx_b]) + SW'(dec_cn[in_rd_idx_b])));
    assign full_dest = in_issue_valid && (cnt_q[in_issue_reg_idx] == CNT_MAX) &&
        !dec_wb[in_issue_reg_idx] && !dec_cn[in_issue_reg_idx];
    assign stall = hazard_a || hazard_b || full_dest;

    always_comb begin
        logic [SW-1:0] sum;
        sum         = '0;
        inc         = '0;
        underflow_d = underflow_q;
        for (int i = 0; i < NREGS; i++) begin
            inc[i] = in_issue_valid && !stall && (in_issue_reg_idx == REG_IDX_WIDTH'(i));
            sum = SW'(cnt_q[i]) + SW'(inc[i]) - SW'(dec_wb[i]) - SW'(dec_cn[i]);
            if (sum[SW-1]) begin
                cnt_d[i]    = '0;
                underflow_d = 1'b1;
            end else begin
                cnt_d[i] = sum[PEND_CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            underflow_q <= 1'b0;
        end else begin
            if (in_act_write_res_to_reg) begin
                regs_q[in_res_reg_idx] <= in_res;
            end
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            underflow_q <= underflow_d;
        end
    end

    assign out_rd_data_a = (in_act_write_res_to_reg && (in_res_reg_idx == in_rd_idx_a))
                         ? in_res : regs_q[in_rd_idx_a];
    assign out_rd_data_b = (in_act_write_res_to_reg && (in_res_reg_idx == in_rd_idx_b))
                         ? in_res : regs_q[in_rd_idx_b];
    assign out_stall         = stall;
    assign out_underflow_err = underflow_q;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
            assign out_busy_mask[gi] = |cnt_q[gi];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Directed self-checking bench for regfile_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        wb;
    logic [15:0] res;
    logic [3:0]  res_idx;
    logic        cancel;
    logic [3:0]  cancel_idx;
    logic [3:0]  rd_a;
    logic [3:0]  rd_b;
    logic        use_a;
    logic        use_b;
    logic        iss;
    logic [3:0]  iss_idx;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic        stall;
    logic [15:0] busy;
    logic        uf;

    int nvec = 0;
    int nerr = 0;

    regfile_scoreboard #(
        .IALU_WORD_WIDTH (16),
        .REG_IDX_WIDTH   (4),
        .PEND_CNT_WIDTH  (2)
    ) dut (
        .clock                   (clk),
        .reset                   (rst),
        .in_act_write_res_to_reg (wb),
        .in_res                  (res),
        .in_res_reg_idx          (res_idx),
        .in_cancel_valid         (cancel),
        .in_cancel_reg_idx       (cancel_idx),
        .in_rd_idx_a             (rd_a),
        .in_rd_idx_b             (rd_b),
        .in_rd_use_a             (use_a),
        .in_rd_use_b             (use_b),
        .in_issue_valid          (iss),
        .in_issue_reg_idx        (iss_idx),
        .out_rd_data_a           (data_a),
        .out_rd_data_b           (data_b),
        .out_stall               (stall),
        .out_busy_mask           (busy),
        .out_underflow_err       (uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        wb = 1'b0; res = '0; res_idx = '0;
        cancel = 1'b0; cancel_idx = '0;
        rd_a = '0; rd_b = '0; use_a = 1'b0; use_b = 1'b0;
        iss = 1'b0; iss_idx = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_a = 4'(i); rd_b = 4'(15 - i); use_a = 1'b1; use_b = 1'b1;
            #1;
            nvec++;
            if (data_a !== 16'h0000 || data_b !== 16'h0000) begin
                nerr++;
                $display("FAIL reset_read idx %0d: got a=%h b=%h want 0000", i, data_a, data_b);
            end
        end
        nvec++;
        if (busy !== 16'h0000) begin nerr++; $display("FAIL reset_busy: got %h want 0000", busy); end
        nvec++;
        if (stall !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %b want 0", stall); end
        nvec++;
        if (uf !== 1'b0) begin nerr++; $display("FAIL reset_underflow: got %b want 0", uf); end
        idle();
    endtask

    task automatic test_bypass();
        iss = 1'b1; iss_idx = 4'd3;
        tick();
        idle();
        wb = 1'b1; res_idx = 4'd3; res = 16'hBEEF; rd_a = 4'd3; use_a = 1'b1;
        #1;
        nvec++;
        if (data_a !== 16'hBEEF) begin nerr++; $display("FAIL bypass_same_cycle: got %h want BEEF", data_a); end
        nvec++;
        if (stall !== 1'b0) begin nerr++; $display("FAIL bypass_stall: got %b want 0", stall); end
        tick();
        idle();
        rd_a = 4'd3; rd_b = 4'd3;
        #1;
        nvec++;
        if (data_a !== 16'hBEEF || data_b !== 16'hBEEF) begin
            nerr++; $display("FAIL bypass_next_cycle: got a=%h b=%h want BEEF", data_a, data_b);
        end
        nvec++;
        if (busy !== 16'h0000 || uf !== 1'b0) begin
            nerr++; $display("FAIL bypass_retired: got busy=%h uf=%b want 0000/0", busy, uf);
        end
        idle();
    endtask

    task automatic test_pending();
        iss = 1'b1; iss_idx = 4'd5;
        tick();
        idle();
        #1;
        nvec++;
        if (busy !== 16'h0020) begin nerr++; $display("FAIL pend_busy: got %h want 0020", busy); end
        rd_a = 4'd5; use_a = 1'b1;
        #1;
        nvec++;
        if (stall !== 1'b1) begin nerr++; $display("FAIL pend_hazard: got %b want 1", stall); end
        wb = 1'b1; res_idx = 4'd5; res = 16'h1234;
        #1;
        nvec++;
        if (stall !== 1'b0 || data_a !== 16'h1234) begin
            nerr++; $display("FAIL pend_wb_bypass: got stall=%b a=%h want 0/1234", stall, data_a);
        end
        tick();
        idle();
        rd_b = 4'd5;
        #1;
        nvec++;
        if (busy !== 16'h0000 || data_b !== 16'h1234) begin
            nerr++; $display("FAIL pend_cleared: got busy=%h b=%h want 0000/1234", busy, data_b);
        end
        idle();
    endtask

    task automatic test_counter_full();
        for (int k = 0; k < 3; k++) begin
            iss = 1'b1; iss_idx = 4'd7;
            tick();
        end
        idle();
        iss = 1'b1; iss_idx = 4'd7;
        #1;
        nvec++;
        if (stall !== 1'b1) begin nerr++; $display("FAIL full_stall: got %b want 1", stall); end
        tick();
        idle();
        #1;
        nvec++;
        if (busy !== 16'h0080) begin nerr++; $display("FAIL full_no_wrap: got %h want 0080", busy); end
        iss = 1'b1; iss_idx = 4'd7; wb = 1'b1; res_idx = 4'd7; res = 16'h0777;
        #1;
        nvec++;
        if (stall !== 1'b0) begin nerr++; $display("FAIL full_with_wb: got %b want 0", stall); end
        tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            wb = 1'b1; res_idx = 4'd7; res = 16'h0700 + 16'(k);
            tick();
        end
        idle();
        #1;
        nvec++;
        if (busy !== 16'h0080) begin nerr++; $display("FAIL full_count_kept: got %h want 0080", busy); end
        wb = 1'b1; res_idx = 4'd7; res = 16'h0702;
        tick();
        idle();
        #1;
        nvec++;
        if (busy !== 16'h0000 || uf !== 1'b0) begin
            nerr++; $display("FAIL full_drained: got busy=%h uf=%b want 0000/0", busy, uf);
        end
    endtask

    task automatic test_underflow();
        idle();
        #1;
        nvec++;
        if (uf !== 1'b0) begin nerr++; $display("FAIL uf_before: got %b want 0", uf); end
        cancel = 1'b1; cancel_idx = 4'd9;
        tick();
        idle();
        #1;
        nvec++;
        if (uf !== 1'b1 || busy !== 16'h0000) begin
            nerr++; $display("FAIL uf_set: got uf=%b busy=%h want 1/0000", uf, busy);
        end
        tick(); tick(); tick();
        nvec++;
        if (uf !== 1'b1) begin nerr++; $display("FAIL uf_sticky: got %b want 1", uf); end
    endtask

    task automatic test_sources();
        iss = 1'b1; iss_idx = 4'd10;
        tick();
        idle();
        rd_a = 4'd3; rd_b = 4'd10; use_b = 1'b1;
        #1;
        nvec++;
        if (stall !== 1'b1) begin nerr++; $display("FAIL src_b_hazard: got %b want 1", stall); end
        use_b = 1'b0;
        #1;
        nvec++;
        if (stall !== 1'b0) begin nerr++; $display("FAIL src_b_unused: got %b want 0", stall); end
        use_b = 1'b1; cancel = 1'b1; cancel_idx = 4'd10;
        #1;
        nvec++;
        if (stall !== 1'b0) begin nerr++; $display("FAIL src_cancel_ready: got %b want 0", stall); end
        tick();
        idle();
        iss = 1'b1; iss_idx = 4'd11;
        tick();
        idle();
        rd_a = 4'd11; use_a = 1'b1; iss = 1'b1; iss_idx = 4'd11;
        #1;
        nvec++;
        if (stall !== 1'b1) begin nerr++; $display("FAIL src_dest_hazard: got %b want 1", stall); end
        tick();
        idle();
        wb = 1'b1; res_idx = 4'd11; res = 16'h0B0B;
        tick();
        idle();
        #1;
        nvec++;
        if (busy !== 16'h0000) begin nerr++; $display("FAIL src_stalled_issue_ignored: got %h want 0000", busy); end
    endtask

    task automatic test_multi_hit();
        iss = 1'b1; iss_idx = 4'd2;
        tick();
        tick();
        idle();
        wb = 1'b1; res_idx = 4'd2; res = 16'h2222;
        cancel = 1'b1; cancel_idx = 4'd2;
        iss = 1'b1; iss_idx = 4'd2;
        #1;
        nvec++;
        if (stall !== 1'b0) begin nerr++; $display("FAIL multi_stall: got %b want 0", stall); end
        tick();
        idle();
        rd_a = 4'd2;
        #1;
        nvec++;
        if (busy !== 16'h0004 || data_a !== 16'h2222) begin
            nerr++; $display("FAIL multi_net: got busy=%h a=%h want 0004/2222", busy, data_a);
        end
        wb = 1'b1; res_idx = 4'd2; res = 16'h2223;
        tick();
        idle();
        #1;
        nvec++;
        if (busy !== 16'h0000) begin nerr++; $display("FAIL multi_drained: got %h want 0000", busy); end
        iss = 1'b1; iss_idx = 4'd4;
        tick();
        idle();
        rst = 1'b1; wb = 1'b1; res_idx = 4'd6; res = 16'hAAAA;
        tick();
        rst = 1'b0;
        idle();
        rd_a = 4'd6; rd_b = 4'd2; use_a = 1'b1; use_b = 1'b1;
        #1;
        nvec++;
        if (data_a !== 16'h0000 || data_b !== 16'h0000) begin
            nerr++; $display("FAIL midreset_regs: got a=%h b=%h want 0000", data_a, data_b);
        end
        nvec++;
        if (busy !== 16'h0000 || uf !== 1'b0 || stall !== 1'b0) begin
            nerr++; $display("FAIL midreset_state: got busy=%h uf=%b stall=%b want 0000/0/0", busy, uf, stall);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_bypass();
        test_pending();
        test_counter_full();
        test_underflow();
        test_sources();
        test_multi_hit();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
